// File: rtl/axi_id_alloc_if.sv
// Handshake and ID bundle between the AXI ID allocator and its integrator.
// The allocator takes the slave modport; whoever drives the bus takes the master modport.
interface axi_id_alloc_if #(
  parameter int unsigned SlvIdWidth = 4,
  parameter int unsigned MstIdWidth = 2
);

  logic [SlvIdWidth-1:0] slv_aw_id_i;
  logic                  aw_valid_i;
  logic                  aw_ready_i;
  logic                  aw_avail_o;
  logic [MstIdWidth-1:0] mst_aw_id_o;

  logic [MstIdWidth-1:0] mst_b_id_i;
  logic                  b_valid_i;
  logic                  b_ready_i;
  logic [SlvIdWidth-1:0] slv_b_id_o;

  logic [SlvIdWidth-1:0] slv_ar_id_i;
  logic                  ar_valid_i;
  logic                  ar_ready_i;
  logic                  ar_avail_o;
  logic [MstIdWidth-1:0] mst_ar_id_o;

  logic [MstIdWidth-1:0] mst_r_id_i;
  logic                  r_valid_i;
  logic                  r_ready_i;
  logic                  r_last_i;
  logic [SlvIdWidth-1:0] slv_r_id_o;

  modport slave (
    input  slv_aw_id_i, aw_valid_i, aw_ready_i,
    output aw_avail_o, mst_aw_id_o,
    input  mst_b_id_i, b_valid_i, b_ready_i,
    output slv_b_id_o,
    input  slv_ar_id_i, ar_valid_i, ar_ready_i,
    output ar_avail_o, mst_ar_id_o,
    input  mst_r_id_i, r_valid_i, r_ready_i, r_last_i,
    output slv_r_id_o
  );

  modport master (
    output slv_aw_id_i, aw_valid_i, aw_ready_i,
    input  aw_avail_o, mst_aw_id_o,
    output mst_b_id_i, b_valid_i, b_ready_i,
    input  slv_b_id_o,
    output slv_ar_id_i, ar_valid_i, ar_ready_i,
    input  ar_avail_o, mst_ar_id_o,
    output mst_r_id_i, r_valid_i, r_ready_i, r_last_i,
    input  slv_r_id_o
  );

endinterface

// File: rtl/axi_id_alloc.sv
// Compresses wide slave-port AXI IDs onto a small master-port ID space, one table per direction.
// Defining AXI_ID_ALLOC_ERR_EN adds a sticky err_o flag for releases that hit an empty entry.
module axi_id_alloc #(
  parameter int unsigned SlvIdWidth   = 4,
  parameter int unsigned MstIdWidth   = 2,
  parameter int unsigned MaxTxnsPerId = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
`ifdef AXI_ID_ALLOC_ERR_EN
  output logic            err_o,
`endif
  axi_id_alloc_if.slave   bus
);

  localparam int unsigned N        = 1 << MstIdWidth;
  localparam int unsigned CntWidth = $clog2(MaxTxnsPerId + 1);
  localparam int unsigned DirW     = 0;
  localparam int unsigned DirR     = 1;

  typedef logic [SlvIdWidth-1:0] slvId_t;
  typedef logic [MstIdWidth-1:0] mstId_t;
  typedef logic [CntWidth-1:0]   cnt_t;

  localparam cnt_t CntMax = cnt_t'(MaxTxnsPerId);

  slvId_t slvId_q [2][N];
  slvId_t slvId_d [2][N];
  cnt_t   cnt_q   [2][N];
  cnt_t   cnt_d   [2][N];
  logic   lockValid_q [2];
  logic   lockValid_d [2];
  mstId_t lockIdx_q   [2];
  mstId_t lockIdx_d   [2];

  logic   reqValid  [2];
  logic   reqReady  [2];
  slvId_t reqId     [2];
  logic   relFire   [2];
  mstId_t relId     [2];

  logic   matchFound [2];
  mstId_t matchIdx   [2];
  logic   freeFound  [2];
  mstId_t freeIdx    [2];
  mstId_t chosenIdx  [2];
  logic   chosenOk   [2];
  logic   avail      [2];
  logic   allocFire  [2];
  logic   relOk      [2];
  logic   incHit     [2][N];
  logic   decHit     [2][N];

  // Fold both channel pairs onto direction-indexed arrays so one datapath serves both tables.
  always_comb begin
    reqValid[DirW] = bus.aw_valid_i;
    reqReady[DirW] = bus.aw_ready_i;
    reqId[DirW]    = bus.slv_aw_id_i;
    relFire[DirW]  = bus.b_valid_i & bus.b_ready_i;
    relId[DirW]    = bus.mst_b_id_i;
    reqValid[DirR] = bus.ar_valid_i;
    reqReady[DirR] = bus.ar_ready_i;
    reqId[DirR]    = bus.slv_ar_id_i;
    relFire[DirR]  = bus.r_valid_i & bus.r_ready_i & bus.r_last_i;
    relId[DirR]    = bus.mst_r_id_i;
  end

  // Index selection: a held request keeps its lock; otherwise reuse the live entry for the
  // same slave ID so ordering is preserved, else the lowest free entry.
  // Availability only looks at registered state, so releases never reach avail combinationally.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      matchFound[d] = 1'b0;
      matchIdx[d]   = '0;
      freeFound[d]  = 1'b0;
      freeIdx[d]    = '0;
      for (int i = 0; i < int'(N); i++) begin
        if (cnt_q[d][i] != '0 && slvId_q[d][i] == reqId[d]) begin
          matchFound[d] = 1'b1;
          matchIdx[d]   = mstId_t'(i);
        end
        if (cnt_q[d][i] == '0 && !freeFound[d]) begin
          freeFound[d] = 1'b1;
          freeIdx[d]   = mstId_t'(i);
        end
      end

      if (lockValid_q[d]) begin
        chosenIdx[d] = lockIdx_q[d];
        chosenOk[d]  = 1'b1;
      end else if (matchFound[d]) begin
        chosenIdx[d] = matchIdx[d];
        chosenOk[d]  = 1'b1;
      end else begin
        chosenIdx[d] = freeIdx[d];
        chosenOk[d]  = freeFound[d];
      end

      avail[d]     = chosenOk[d] && (cnt_q[d][chosenIdx[d]] < CntMax);
      allocFire[d] = reqValid[d] && reqReady[d] && avail[d];
`ifdef AXI_ID_ALLOC_ERR_EN
      relOk[d]     = relFire[d] && (cnt_q[d][relId[d]] != '0);
`else
      relOk[d]     = relFire[d];
`endif

      lockValid_d[d] = !allocFire[d] && reqValid[d] && chosenOk[d];
      lockIdx_d[d]   = lockValid_d[d] ? chosenIdx[d] : '0;

      for (int i = 0; i < int'(N); i++) begin
        incHit[d][i]  = allocFire[d] && (chosenIdx[d] == mstId_t'(i));
        decHit[d][i]  = relOk[d] && (relId[d] == mstId_t'(i));
        slvId_d[d][i] = incHit[d][i] ? reqId[d] : slvId_q[d][i];
        cnt_d[d][i]   = cnt_q[d][i] + cnt_t'(incHit[d][i]) - cnt_t'(decHit[d][i]);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int d = 0; d < 2; d++) begin
        lockValid_q[d] <= 1'b0;
        lockIdx_q[d]   <= '0;
        for (int i = 0; i < int'(N); i++) begin
          slvId_q[d][i] <= '0;
          cnt_q[d][i]   <= '0;
        end
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        lockValid_q[d] <= lockValid_d[d];
        lockIdx_q[d]   <= lockIdx_d[d];
        for (int i = 0; i < int'(N); i++) begin
          slvId_q[d][i] <= slvId_d[d][i];
          cnt_q[d][i]   <= cnt_d[d][i];
        end
      end
    end
  end

`ifdef AXI_ID_ALLOC_ERR_EN
  logic err_q;
  logic err_d;

  // Sticky until reset: any release that lands on an empty entry.
  always_comb begin
    err_d = err_q | (relFire[DirW] & ~relOk[DirW]) | (relFire[DirR] & ~relOk[DirR]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`endif

  assign bus.aw_avail_o  = avail[DirW];
  assign bus.mst_aw_id_o = chosenIdx[DirW];
  assign bus.slv_b_id_o  = slvId_q[DirW][bus.mst_b_id_i];
  assign bus.ar_avail_o  = avail[DirR];
  assign bus.mst_ar_id_o = chosenIdx[DirR];
  assign bus.slv_r_id_o  = slvId_q[DirR][bus.mst_r_id_i];

endmodule

// File: tb/tb_axi_id_alloc.sv
// Directed self-checking bench for axi_id_alloc with the default 4-bit/2-bit/4-deep setup.
// The sticky error flag is exercised only when AXI_ID_ALLOC_ERR_EN is defined.
module tb_axi_id_alloc;

  logic clk;
  logic rst_n;
  int   compCount;
  int   failCount;
`ifdef AXI_ID_ALLOC_ERR_EN
  logic err;
`endif

  axi_id_alloc_if #(.SlvIdWidth(4), .MstIdWidth(2)) bus ();

  axi_id_alloc #(
    .SlvIdWidth  (4),
    .MstIdWidth  (2),
    .MaxTxnsPerId(4)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
`ifdef AXI_ID_ALLOC_ERR_EN
    .err_o (err),
`endif
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic setAw(input logic v, input logic r, input logic [3:0] id);
    bus.aw_valid_i  = v;
    bus.aw_ready_i  = r;
    bus.slv_aw_id_i = id;
  endtask

  task automatic setAr(input logic v, input logic r, input logic [3:0] id);
    bus.ar_valid_i  = v;
    bus.ar_ready_i  = r;
    bus.slv_ar_id_i = id;
  endtask

  task automatic setB(input logic v, input logic [1:0] id);
    bus.b_valid_i  = v;
    bus.b_ready_i  = v;
    bus.mst_b_id_i = id;
  endtask

  task automatic setR(input logic v, input logic [1:0] id, input logic last);
    bus.r_valid_i  = v;
    bus.r_ready_i  = v;
    bus.mst_r_id_i = id;
    bus.r_last_i   = last;
  endtask

  task automatic settle();
    #1;
  endtask

  // Commit the current inputs on the next rising edge and return just after the falling edge.
  task automatic applyStimulus();
    @(negedge clk);
  endtask

  initial begin
    compCount = 0;
    failCount = 0;
    rst_n = 1'b0;
    setAw(0, 0, 0);
    setAr(0, 0, 0);
    setB(0, 0);
    setR(0, 0, 0);
    settle();
    checkOutput("rst_aw_avail", 32'(bus.aw_avail_o), 1);
    checkOutput("rst_ar_avail", 32'(bus.ar_avail_o), 1);
    checkOutput("rst_mst_aw_id", 32'(bus.mst_aw_id_o), 0);
    checkOutput("rst_mst_ar_id", 32'(bus.mst_ar_id_o), 0);
`ifdef AXI_ID_ALLOC_ERR_EN
    checkOutput("rst_err", 32'(err), 0);
`endif
    applyStimulus();
    applyStimulus();
    rst_n = 1'b1;
    applyStimulus();

    $display("[TB] basic allocate and release");
    setAw(1, 1, 5); settle();
    checkOutput("aw5_id", 32'(bus.mst_aw_id_o), 0);
    checkOutput("aw5_avail", 32'(bus.aw_avail_o), 1);
    applyStimulus();
    setAw(1, 1, 9); settle();
    checkOutput("aw9_id", 32'(bus.mst_aw_id_o), 1);
    applyStimulus();
    setAw(0, 0, 12); setB(1, 0); settle();
    checkOutput("b0_slv_id", 32'(bus.slv_b_id_o), 5);
    applyStimulus();
    setB(0, 0); settle();
    checkOutput("entry0_freed", 32'(bus.mst_aw_id_o), 0);
    setB(1, 1); settle();
    checkOutput("b1_slv_id", 32'(bus.slv_b_id_o), 9);
    applyStimulus();
    setB(0, 0);

    $display("[TB] same id up to the per-entry limit");
    for (int k = 0; k < 4; k++) begin
      setAw(1, 1, 3); settle();
      checkOutput("aw3_id", 32'(bus.mst_aw_id_o), 0);
      checkOutput("aw3_avail", 32'(bus.aw_avail_o), 1);
      applyStimulus();
    end
    setAw(1, 1, 3); settle();
    checkOutput("aw3_full_avail", 32'(bus.aw_avail_o), 0);
    checkOutput("aw3_full_id", 32'(bus.mst_aw_id_o), 0);
    applyStimulus();
    setB(1, 0); settle();
    checkOutput("aw3_same_cycle_b", 32'(bus.aw_avail_o), 0);
    applyStimulus();
    setB(0, 0); settle();
    checkOutput("aw3_after_b_avail", 32'(bus.aw_avail_o), 1);
    checkOutput("aw3_after_b_id", 32'(bus.mst_aw_id_o), 0);
    applyStimulus();
    setAw(0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      setB(1, 0); settle();
      checkOutput("drain3_slv_id", 32'(bus.slv_b_id_o), 3);
      applyStimulus();
    end
    setB(0, 0);

    $display("[TB] table full with distinct ids");
    setAw(1, 1, 1); settle(); checkOutput("aw1_id", 32'(bus.mst_aw_id_o), 0); applyStimulus();
    setAw(1, 1, 2); settle(); checkOutput("aw2_id", 32'(bus.mst_aw_id_o), 1); applyStimulus();
    setAw(1, 1, 4); settle(); checkOutput("aw4_id", 32'(bus.mst_aw_id_o), 2); applyStimulus();
    setAw(1, 1, 6); settle(); checkOutput("aw6_id", 32'(bus.mst_aw_id_o), 3); applyStimulus();
    setAw(1, 1, 8); settle();
    checkOutput("aw8_full_avail", 32'(bus.aw_avail_o), 0);
    applyStimulus();
    setB(1, 2); settle();
    checkOutput("b2_slv_id", 32'(bus.slv_b_id_o), 4);
    checkOutput("aw8_no_comb_path", 32'(bus.aw_avail_o), 0);
    applyStimulus();
    setB(0, 0); settle();
    checkOutput("aw8_next_avail", 32'(bus.aw_avail_o), 1);
    checkOutput("aw8_next_id", 32'(bus.mst_aw_id_o), 2);
    applyStimulus();
    setAw(0, 0, 0);

    $display("[TB] held AW keeps its index");
    setB(1, 3); settle();
    checkOutput("b3_slv_id", 32'(bus.slv_b_id_o), 6);
    applyStimulus();
    setB(0, 0); setAw(1, 0, 11); settle();
    checkOutput("hold_first_id", 32'(bus.mst_aw_id_o), 3);
    checkOutput("hold_first_avail", 32'(bus.aw_avail_o), 1);
    applyStimulus();
    setB(1, 0); settle();
    checkOutput("b0_slv_id_1", 32'(bus.slv_b_id_o), 1);
    checkOutput("hold_during_b", 32'(bus.mst_aw_id_o), 3);
    applyStimulus();
    setB(0, 0); settle();
    checkOutput("hold_after_free", 32'(bus.mst_aw_id_o), 3);
    applyStimulus();
    settle();
    checkOutput("hold_later", 32'(bus.mst_aw_id_o), 3);
    setAw(1, 1, 11); settle();
    checkOutput("hold_fire_id", 32'(bus.mst_aw_id_o), 3);
    applyStimulus();
    setAw(0, 0, 13); settle();
    checkOutput("lock_cleared", 32'(bus.mst_aw_id_o), 0);
    setB(1, 1); settle(); checkOutput("clean_b1", 32'(bus.slv_b_id_o), 2); applyStimulus();
    setB(1, 2); settle(); checkOutput("clean_b2", 32'(bus.slv_b_id_o), 8); applyStimulus();
    setB(1, 3); settle(); checkOutput("clean_b3", 32'(bus.slv_b_id_o), 11); applyStimulus();
    setB(0, 0);

    $display("[TB] read burst release on last beat");
    setAr(1, 1, 7); settle();
    checkOutput("ar7_id", 32'(bus.mst_ar_id_o), 0);
    applyStimulus();
    setAr(0, 0, 9);
    for (int k = 0; k < 3; k++) begin
      setR(1, 0, 0); settle();
      checkOutput("r_beat_slv_id", 32'(bus.slv_r_id_o), 7);
      applyStimulus();
    end
    setR(0, 0, 0); settle();
    checkOutput("ar_busy_before_last", 32'(bus.mst_ar_id_o), 1);
    setR(1, 0, 1); settle();
    checkOutput("r_last_slv_id", 32'(bus.slv_r_id_o), 7);
    applyStimulus();
    setR(0, 0, 0); settle();
    checkOutput("ar_freed_after_last", 32'(bus.mst_ar_id_o), 0);
    setAr(1, 1, 7); applyStimulus();
    setR(1, 0, 1); settle();
    checkOutput("ar_simul_id", 32'(bus.mst_ar_id_o), 0);
    checkOutput("ar_simul_avail", 32'(bus.ar_avail_o), 1);
    applyStimulus();
    setAr(0, 0, 9); setR(0, 0, 0); settle();
    checkOutput("ar_simul_cnt_kept", 32'(bus.mst_ar_id_o), 1);
    setR(1, 0, 1); applyStimulus();
    setR(0, 0, 0); settle();
    checkOutput("ar_final_free", 32'(bus.mst_ar_id_o), 0);

`ifdef AXI_ID_ALLOC_ERR_EN
    $display("[TB] release to empty entry");
    setB(1, 3); settle();
    checkOutput("err_before", 32'(err), 0);
    applyStimulus();
    setB(0, 0); settle();
    checkOutput("err_set", 32'(err), 1);
    applyStimulus();
    settle();
    checkOutput("err_held", 32'(err), 1);
`endif

    $display("[TB] reset mid-traffic");
    setAw(1, 1, 5); applyStimulus();
    setAw(1, 1, 9); applyStimulus();
    setAw(1, 0, 12); settle();
    checkOutput("pre_rst_id", 32'(bus.mst_aw_id_o), 2);
    applyStimulus();
    setAr(1, 1, 6); applyStimulus();
    setAr(0, 0, 0);
    #2 rst_n = 1'b0;
    settle();
    checkOutput("mid_rst_aw_avail", 32'(bus.aw_avail_o), 1);
    checkOutput("mid_rst_aw_id", 32'(bus.mst_aw_id_o), 0);
    checkOutput("mid_rst_ar_avail", 32'(bus.ar_avail_o), 1);
    checkOutput("mid_rst_ar_id", 32'(bus.mst_ar_id_o), 0);
`ifdef AXI_ID_ALLOC_ERR_EN
    checkOutput("mid_rst_err", 32'(err), 0);
`endif
    setAw(0, 0, 9);
    applyStimulus();
    rst_n = 1'b1;
    applyStimulus();
    settle();
    checkOutput("post_rst_discard", 32'(bus.mst_aw_id_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule
